// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB maintenance controller.
// Maintenance op encodings, FSM states and the LFSR tap table for the fill index.
package tlb_pkg;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRCH,
        S_RD,
        S_WR,
        S_INV,
        S_RESP
    } tlb_state_e;

    localparam logic [4:0] INVOP_MAX = 5'd6;

    // Feedback masks of primitive polynomials, one per register width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h3;
            3:       return 32'h6;
            4:       return 32'hC;
            5:       return 32'h14;
            6:       return 32'h30;
            7:       return 32'h60;
            8:       return 32'hB8;
            9:       return 32'h110;
            10:      return 32'h240;
            default: return 32'hC;
        endcase
    endfunction

endpackage

// File: rtl/tlb_fill_idx.sv
// Free-running replacement index for TLBFILL.
// Define TLB_FILL_LFSR_EN to use a maximal-length Fibonacci LFSR instead of a counter.
module tlb_fill_idx
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [IW-1:0] fill_idx
);

`ifdef TLB_FILL_LFSR_EN
    localparam logic [IW-1:0] TAPS = IW'(lfsr_taps(IW));

    // Seeded non-zero so the all-zero lock-up state is unreachable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fill_idx <= IW'(1);
        else         fill_idx <= {fill_idx[IW-2:0], ^(fill_idx & TAPS)};
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          fill_idx <= '0;
        else if (fill_idx == IW'(TLBNUM - 1)) fill_idx <= '0;
        else                                  fill_idx <= fill_idx + IW'(1);
    end
`endif

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB ports with a valid/ready response.
// Fill index source selected by TLB_FILL_LFSR_EN (see tlb_fill_idx).
module tlb_maint_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_invop,
    input  logic [9:0]    req_asid,
    input  logic [18:0]   req_vppn,
    input  logic [IW-1:0] req_index,
    input  tlb_entry_t    req_entry,
    input  logic [18:0]   mem_vppn,
    input  logic          mem_va_bit12,
    input  logic [9:0]    mem_asid,
    output logic          mem_stall,
    output logic [18:0]   s1_vppn,
    output logic          s1_va_bit12,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output tlb_entry_t    w_entry,
    output logic [IW-1:0] r_index,
    input  tlb_entry_t    r_entry,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_found,
    output logic [IW-1:0] resp_index,
    output tlb_entry_t    resp_entry,
    output logic          resp_err
);

    tlb_state_e    state, state_nxt;
    logic          accept;
    logic [IW-1:0] fill_idx;

    logic [4:0]    invop_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic [IW-1:0] index_q;
    tlb_entry_t    entry_q;

    assign accept = req_valid && req_ready;

    tlb_fill_idx #(.TLBNUM(TLBNUM)) u_fill_idx (
        .clk      (clk),
        .resetn   (resetn),
        .fill_idx (fill_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                case (req_op)
                    OP_SRCH:         state_nxt = S_SRCH;
                    OP_RD:           state_nxt = S_RD;
                    OP_WR, OP_FILL:  state_nxt = S_WR;
                    OP_INV:          state_nxt = S_INV;
                    default:         state_nxt = S_RESP;
                endcase
            end
            S_SRCH, S_RD, S_WR, S_INV: state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        req_ready    = (state == S_IDLE);
        resp_valid   = (state == S_RESP);
        mem_stall    = 1'b0;
        s1_vppn      = mem_vppn;
        s1_va_bit12  = mem_va_bit12;
        s1_asid      = mem_asid;
        we           = 1'b0;
        w_index      = index_q;
        w_entry      = entry_q;
        r_index      = index_q;
        invtlb_valid = 1'b0;
        invtlb_op    = invop_q;
        case (state)
            S_SRCH: begin
                mem_stall   = 1'b1;
                s1_vppn     = vppn_q;
                s1_va_bit12 = 1'b0;
                s1_asid     = asid_q;
            end
            S_WR: we = 1'b1;
            S_INV: if (invop_q <= INVOP_MAX) begin
                invtlb_valid = 1'b1;
                mem_stall    = 1'b1;
                s1_vppn      = vppn_q;
                s1_va_bit12  = 1'b0;
                s1_asid      = asid_q;
            end
            default: ;
        endcase
    end

    // Operand latch and response capture; resp_* only change outside RESP, so they hold while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            invop_q    <= '0;
            asid_q     <= '0;
            vppn_q     <= '0;
            index_q    <= '0;
            entry_q    <= '0;
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_entry <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    invop_q    <= req_invop;
                    asid_q     <= req_asid;
                    vppn_q     <= req_vppn;
                    index_q    <= (req_op == OP_FILL) ? fill_idx : req_index;
                    entry_q    <= req_entry;
                    resp_found <= 1'b0;
                    resp_index <= '0;
                    resp_entry <= '0;
                    resp_err   <= (req_op > OP_INV);
                end
                S_SRCH: begin
                    resp_found <= s1_found;
                    resp_index <= s1_index;
                end
                S_RD: begin
                    // An invalid entry reads back fully cleared, e included.
                    resp_found <= r_entry.e;
                    resp_index <= index_q;
                    resp_entry <= r_entry.e ? r_entry : '0;
                end
                S_WR:  resp_index <= index_q;
                S_INV: resp_err   <= (invop_q > INVOP_MAX);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl with a behavioural TLB behind the search/read/write ports.
module tb_tlb_maint_ctrl;
    import tlb_pkg::*;

    localparam int TLBNUM = 16;
    localparam int IW     = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0, req_ready;
    logic [2:0]    req_op = '0;
    logic [4:0]    req_invop = '0;
    logic [9:0]    req_asid = '0;
    logic [18:0]   req_vppn = '0;
    logic [IW-1:0] req_index = '0;
    tlb_entry_t    req_entry = '0;
    logic [18:0]   mem_vppn = '0;
    logic          mem_va_bit12 = 1'b0;
    logic [9:0]    mem_asid = '0;
    logic          mem_stall;
    logic [18:0]   s1_vppn;
    logic          s1_va_bit12;
    logic [9:0]    s1_asid;
    logic          s1_found;
    logic [IW-1:0] s1_index;
    logic          we;
    logic [IW-1:0] w_index;
    tlb_entry_t    w_entry;
    logic [IW-1:0] r_index;
    tlb_entry_t    r_entry;
    logic          invtlb_valid;
    logic [4:0]    invtlb_op;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_found;
    logic [IW-1:0] resp_index;
    tlb_entry_t    resp_entry;
    logic          resp_err;

    tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_invop(req_invop),
        .req_asid(req_asid), .req_vppn(req_vppn), .req_index(req_index), .req_entry(req_entry),
        .mem_vppn(mem_vppn), .mem_va_bit12(mem_va_bit12), .mem_asid(mem_asid), .mem_stall(mem_stall),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .we(we), .w_index(w_index), .w_entry(w_entry), .r_index(r_index), .r_entry(r_entry),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
        .resp_index(resp_index), .resp_entry(resp_entry), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // TLB stand-in: entry 3 holds vppn 0x12345 / asid 5; writes land in a small array.
    tlb_entry_t tlb_mem [TLBNUM];
    int         wr9_cnt = 0;
    assign s1_found = (s1_vppn == 19'h12345) && (s1_asid == 10'd5);
    assign s1_index = s1_found ? 4'd3 : 4'd0;
    assign r_entry  = tlb_mem[r_index];
    always @(posedge clk) begin
        if (we) begin
            tlb_mem[w_index] <= w_entry;
            if (w_index == 4'd9) wr9_cnt <= wr9_cnt + 1;
        end
    end

    int            we_cnt = 0, inv_cnt = 0, stall_cnt = 0, clash_cnt = 0;
    logic [IW-1:0] last_w_index = '0;
    logic [4:0]    last_inv_op = '0;
    logic [IW-1:0] w_hist [$];
    always @(negedge clk) begin
        if (we) begin
            we_cnt++;
            last_w_index = w_index;
            w_hist.push_back(w_index);
        end
        if (invtlb_valid) begin
            inv_cnt++;
            last_inv_op = invtlb_op;
        end
        if (mem_stall) stall_cnt++;
        if (we && invtlb_valid) clash_cnt++;
    end

    int chk_cnt = 0, pass_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int wait_n, we0, inv0, st0;

    // Present one request, drop it after acceptance, then wait (bounded) for resp_valid.
    task automatic issue(input logic [2:0] op, input logic [4:0] invop, input logic [9:0] asid,
                         input logic [18:0] vppn, input logic [IW-1:0] idx, input tlb_entry_t ent);
        we0 = we_cnt; inv0 = inv_cnt; st0 = stall_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_invop = invop;
        req_asid = asid; req_vppn = vppn; req_index = idx; req_entry = ent;
        @(negedge clk);
        req_valid = 1'b0;
        wait_n = 0;
        while (!resp_valid && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("resp_arrives", resp_valid, 1'b1);
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("back_to_idle", req_ready, 1'b1);
    endtask

    tlb_entry_t    ent;
    logic [IW-1:0] diff;
    int            h0;

    initial begin
        ent = '{e: 1'b1, vppn: 19'h2abcd, ps: 6'd12, asid: 10'd5, g: 1'b0,
                ppn0: 20'h12345, plv0: 2'd3, mat0: 2'd1, d0: 1'b1, v0: 1'b1,
                ppn1: 20'h54321, plv1: 2'd0, mat1: 2'd2, d1: 1'b0, v1: 1'b1};

        #12;
        check("rst_req_ready",  req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_we",         we, 1'b0);
        check("rst_invtlb",     invtlb_valid, 1'b0);
        check("rst_mem_stall",  mem_stall, 1'b0);
        check("rst_resp_flds",  {resp_found, resp_index, resp_err}, '0);
        @(negedge clk);
        resetn = 1'b1;

        mem_vppn = 19'h70f0f; mem_asid = 10'h155; mem_va_bit12 = 1'b1;
        #1;
        check("idle_s1_vppn",  s1_vppn, 19'h70f0f);
        check("idle_s1_asid",  s1_asid, 10'h155);
        check("idle_s1_bit12", s1_va_bit12, 1'b1);

        // Search hit, then hold resp_ready low for five cycles.
        issue(OP_SRCH, 5'd0, 10'd5, 19'h12345, 4'd0, '0);
        check("srch_latency", wait_n, 1);
        check("srch_stall",   stall_cnt - st0, 1);
        check("srch_found",   resp_found, 1'b1);
        check("srch_index",   resp_index, 4'd3);
        check("srch_err",     resp_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp", {resp_valid, req_ready, resp_found, resp_index, resp_err},
                  {1'b1, 1'b0, 1'b1, 4'd3, 1'b0});
        end
        ack();

        issue(OP_SRCH, 5'd0, 10'd5, 19'h11111, 4'd0, '0);
        check("miss_found", resp_found, 1'b0);
        ack();

        issue(OP_WR, 5'd0, 10'd0, 19'd0, 4'd7, ent);
        check("wr_we_once",  we_cnt - we0, 1);
        check("wr_w_index",  last_w_index, 4'd7);
        check("wr_no_inv",   inv_cnt - inv0, 0);
        check("wr_latency",  wait_n, 1);
        ack();

        issue(OP_RD, 5'd0, 10'd0, 19'd0, 4'd7, '0);
        check("rd_entry",   resp_entry, ent);
        check("rd_no_we",   we_cnt - we0, 0);
        check("rd_nostall", stall_cnt - st0, 0);
        ack();

        issue(OP_INV, 5'd5, 10'd5, 19'h12345, 4'd0, '0);
        check("inv5_pulse", inv_cnt - inv0, 1);
        check("inv5_op",    last_inv_op, 5'd5);
        check("inv5_err",   resp_err, 1'b0);
        check("inv5_no_we", we_cnt - we0, 0);
        ack();

        issue(OP_INV, 5'd9, 10'd5, 19'h12345, 4'd0, '0);
        check("inv9_pulse", inv_cnt - inv0, 0);
        check("inv9_err",   resp_err, 1'b1);
        ack();

        issue(3'd6, 5'd0, 10'd0, 19'd0, 4'd0, '0);
        check("illegal_err",     resp_err, 1'b1);
        check("illegal_latency", wait_n, 0);
        check("illegal_no_we",   we_cnt - we0, 0);
        ack();

        // Two FILLs accepted exactly three cycles apart.
        h0 = w_hist.size();
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_FILL; req_entry = ent; resp_ready = 1'b1;
        repeat (4) @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        resp_ready = 1'b0;
        check("fill_writes", w_hist.size() - h0, 2);
        if (w_hist.size() >= h0 + 2) begin
`ifdef TLB_FILL_LFSR_EN
            check("fill0_nonzero", w_hist[h0] != 4'd0, 1'b1);
            check("fill1_nonzero", w_hist[h0+1] != 4'd0, 1'b1);
`else
            diff = w_hist[h0+1] - w_hist[h0];
            check("fill_delta", diff, 4'd3);
`endif
        end

        check("no_we_inv_clash", clash_cnt, 0);

        // Reset while WR is in flight must drop the write.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_WR; req_index = 4'd9; req_entry = ent;
        @(negedge clk);
        req_valid = 1'b0;
        check("wr9_in_flight", we, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_wr_we",    we, 1'b0);
        check("rst_wr_ready", req_ready, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_dropped", wr9_cnt, 0);
        check("rst_wr_idle",    {req_ready, resp_valid}, 2'b10);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
